// File: rtl/fft_wr_addr_generator.sv
// Write-back address generator for one radix-2 FFT stage: takes butterfly result
// pairs and writes top/bottom samples to their in-place memory addresses.
module fft_wr_addr_generator #(
  parameter int N      = 16,
  parameter int SIZE   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_stage,
  input  logic [2:0]        stage,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_top,
  input  logic [DATA_W-1:0] in_bot,
  output logic              in_ready,
  output logic              en_wr,
  output logic [SIZE-1:0]   wr_ptr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done_stage
);

  localparam int KW = SIZE - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);

  typedef enum logic [2:0] {IDLE, WAIT, WR_TOP, WR_BOT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [KW-1:0]       k_reg, k_next;
  logic [2:0]          s_reg, s_next;
  logic [DATA_W-1:0]   bot_cap_reg, bot_cap_next;
  logic                en_wr_reg, en_wr_next;
  logic [SIZE-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic                handshake;

  // Insert a zero at bit position s of k: the upper element of butterfly k.
  function automatic logic [SIZE-1:0] top_addr(input logic [KW-1:0] k, input logic [2:0] s);
    logic [SIZE-1:0] kx;
    logic [SIZE-1:0] span;
    kx   = {1'b0, k};
    span = SIZE'(1) << s;
    return ((kx >> s) << ({1'b0, s} + 4'd1)) | (kx & (span - SIZE'(1)));
  endfunction

  function automatic logic [SIZE-1:0] bot_addr(input logic [KW-1:0] k, input logic [2:0] s);
    return top_addr(k, s) | (SIZE'(1) << s);
  endfunction

  assign in_ready   = (state_reg == WAIT) || ((state_reg == WR_BOT) && (k_reg != K_LAST));
  assign handshake  = in_valid && in_ready;
  assign done_stage = (state_reg == DONE);
  assign en_wr      = en_wr_reg;
  assign wr_ptr     = wr_ptr_reg;
  assign wr_data    = wr_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      s_reg       <= '0;
      bot_cap_reg <= '0;
      en_wr_reg   <= 1'b0;
      wr_ptr_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      s_reg       <= s_next;
      bot_cap_reg <= bot_cap_next;
      en_wr_reg   <= en_wr_next;
      wr_ptr_reg  <= wr_ptr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    s_next       = s_reg;
    bot_cap_next = bot_cap_reg;
    en_wr_next   = 1'b0;
    wr_ptr_next  = wr_ptr_reg;
    wr_data_next = wr_data_reg;

    case (state_reg)
      IDLE: begin
        if (start_stage) begin
          state_next = WAIT;
          k_next     = '0;
          if (int'(stage) > SIZE - 1) s_next = 3'(SIZE - 1);
          else                        s_next = stage;
        end
      end
      WAIT: begin
        if (handshake) begin
          state_next   = WR_TOP;
          en_wr_next   = 1'b1;
          wr_ptr_next  = top_addr(k_reg, s_reg);
          wr_data_next = in_top;
          bot_cap_next = in_bot;
        end
      end
      WR_TOP: begin
        state_next   = WR_BOT;
        en_wr_next   = 1'b1;
        wr_ptr_next  = bot_addr(k_reg, s_reg);
        wr_data_next = bot_cap_reg;
      end
      WR_BOT: begin
        k_next = k_reg + KW'(1);
        if (k_reg == K_LAST) begin
          state_next = DONE;
        end else if (handshake) begin
          // Next pair's top write overlaps this exit so pairs stream every 2 cycles.
          state_next   = WR_TOP;
          en_wr_next   = 1'b1;
          wr_ptr_next  = top_addr(k_reg + KW'(1), s_reg);
          wr_data_next = in_top;
          bot_cap_next = in_bot;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_wr_addr_generator.sv
// Scoreboard bench for fft_wr_addr_generator (N=16): stimulus queues expected
// writes, a negedge monitor pops and compares every en_wr cycle.
module tb_fft_wr_addr_generator;

  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_stage = 1'b0;
  logic [2:0]      stage = 3'd0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_top = '0;
  logic [DW-1:0]   in_bot = '0;
  logic            in_ready;
  logic            en_wr;
  logic [SIZE-1:0] wr_ptr;
  logic [DW-1:0]   wr_data;
  logic            done_stage;

  fft_wr_addr_generator #(.N(N), .SIZE(SIZE), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stage(start_stage),
    .stage      (stage),
    .in_valid   (in_valid),
    .in_top     (in_top),
    .in_bot     (in_bot),
    .in_ready   (in_ready),
    .en_wr      (en_wr),
    .wr_ptr     (wr_ptr),
    .wr_data    (wr_data),
    .done_stage (done_stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SIZE-1:0] ptr;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   wr_cyc_q[$];
  int   acc_q[$];
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   n_vec = 0;
  int   n_err = 0;

  // Hand-computed top addresses per stage (k = 0..7); bottom = top + span.
  int top_tab [4][8];
  int span_tab [4];

  // Monitor: one line per observed write.
  initial forever begin
    @(negedge clk);
    if (done_stage) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (en_wr) begin
      wr_cyc_q.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got ptr=%0d data=%h, required no write", wr_ptr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_ptr !== mon_e.ptr || wr_data !== mon_e.data) begin
          n_err++;
          $display("FAIL write: got ptr=%0d data=%h, required ptr=%0d data=%h",
                   wr_ptr, wr_data, mon_e.ptr, mon_e.data);
        end else begin
          $display("write cyc=%0d ptr=%0d data=%h ok", cyc, wr_ptr, wr_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_pair(input int st, input int k, input logic [DW-1:0] td,
                           input logic [DW-1:0] bd, input bit push);
    int   guard;
    exp_t e;
    in_valid = 1'b1;
    in_top   = td;
    in_bot   = bd;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout: in_ready stayed %0b for pair %0d, required 1", in_ready, k);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.ptr  = SIZE'(top_tab[st][k]);
      e.data = td;
      exp_q.push_back(e);
      e.ptr  = SIZE'(top_tab[st][k] + span_tab[st]);
      e.data = bd;
      exp_q.push_back(e);
    end
    tick();
    acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] stg);
    start_stage = 1'b1;
    stage       = stg;
    tick();
    start_stage = 1'b0;
  endtask

  task automatic run_stage(input logic [2:0] stg, input int st, input int gap,
                           input int stall, input bit poke, input int run_id);
    int wr_base, done_base, g, last;
    pulse_start(stg);
    wr_base   = wr_cyc_q.size();
    done_base = done_cnt;
    acc_q.delete();
    if (poke) begin
      pulse_start(3'd3);
      check("start_ignored_in_wait", in_ready, 1);
    end
    if (stall > 0) begin
      repeat (stall) tick();
      check("wait_stall_ready", in_ready, 1);
      check("wait_stall_no_write", wr_cyc_q.size(), wr_base);
    end
    for (int k = 0; k < N / 2; k++) begin
      if (k > 0 && gap > 0) repeat (gap) tick();
      send_pair(st, k, {8'hA0, 8'(run_id), 8'(k), 8'h5A}, {8'hB0, 8'(run_id), 8'(k), 8'hC3}, 1'b1);
    end
    if (gap > 0) begin
      check("ready_low_wr_top_final", in_ready, 0);
      tick();
      check("ready_low_wr_bot_final", in_ready, 0);
    end
    g = 0;
    while (done_cnt == done_base && g < 10) begin
      @(negedge clk);
      #1;
      g++;
    end
    repeat (3) tick();
    check("done_pulse_count", done_cnt - done_base, 1);
    check("write_count", wr_cyc_q.size() - wr_base, N);
    check("scoreboard_drained", exp_q.size(), 0);
    if (wr_cyc_q.size() >= wr_base + N && acc_q.size() == N / 2) begin
      last = wr_cyc_q[wr_base + N - 1];
      check("done_after_last_write", done_cyc, last + 1);
      if (gap == 0) check("writes_consecutive", last - wr_cyc_q[wr_base], N - 1);
      for (int k = 0; k < N / 2; k++) begin
        check($sformatf("top_latency_p%0d", k), wr_cyc_q[wr_base + 2 * k], acc_q[k]);
        check($sformatf("bot_latency_p%0d", k), wr_cyc_q[wr_base + 2 * k + 1], acc_q[k] + 1);
      end
    end
    $display("stage run %0d (stage=%0d) finished", run_id, stg);
  endtask

  initial begin
    int wr_base, done_base;
    top_tab = '{'{0, 2, 4, 6, 8, 10, 12, 14},
                '{0, 1, 4, 5, 8, 9, 12, 13},
                '{0, 1, 2, 3, 8, 9, 10, 11},
                '{0, 1, 2, 3, 4, 5, 6, 7}};
    span_tab = '{1, 2, 4, 8};

    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_en_wr", en_wr, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done_stage", done_stage, 0);
    rst = 1'b0;
    tick();

    run_stage(3'd0, 0, 0, 0, 1'b0, 1);

    // in_valid in IDLE must not be consumed.
    wr_base  = wr_cyc_q.size();
    in_valid = 1'b1;
    repeat (4) tick();
    check("idle_no_ready", in_ready, 0);
    check("idle_no_write", wr_cyc_q.size(), wr_base);
    in_valid = 1'b0;
    tick();

    run_stage(3'd2, 2, 0, 0, 1'b0, 2);
    run_stage(3'd3, 3, 0, 0, 1'b0, 3);
    run_stage(3'd6, 3, 0, 0, 1'b0, 4);
    run_stage(3'd1, 1, 2, 10, 1'b0, 5);

    // Reset after the third accepted pair: its writes must never appear.
    pulse_start(3'd0);
    wr_base   = wr_cyc_q.size();
    done_base = done_cnt;
    send_pair(0, 0, 32'h1111_0000, 32'h1111_0001, 1'b1);
    send_pair(0, 1, 32'h2222_0000, 32'h2222_0001, 1'b1);
    send_pair(0, 2, 32'h3333_0000, 32'h3333_0001, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_en_wr", en_wr, 0);
    check("async_rst_wr_ptr", wr_ptr, 0);
    check("async_rst_wr_data", wr_data, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_done", done_stage, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    check("rst_abandon_writes", wr_cyc_q.size() - wr_base, 4);
    check("rst_abandon_no_done", done_cnt - done_base, 0);
    check("rst_abandon_drained", exp_q.size(), 0);

    run_stage(3'd0, 0, 0, 0, 1'b1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation reached %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
